dca_matrix_move_controller: RTL and testbench



---
 rtl/dca_matrix_move_controller_pkg.sv | 35 +++
 rtl/dca_matrix_move_row_counter.sv | 37 +++
 rtl/dca_matrix_move_controller.sv | 116 +++++++++++
 tb/tb_dca_matrix_move_controller.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dca_matrix_move_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dca_matrix_move_controller_pkg
// Purpose  : Shared opcode values, FSM state encoding and opcode decoder for
//            the DCA matrix move controller.
// Contents : OPC_* command opcodes, state_t, decode_opcode()
// Revision : 1.0 - initial release
// ============================================================================
package dca_matrix_move_controller_pkg;

  localparam logic [1:0] OPC_INIT       = 2'd0;
  localparam logic [1:0] OPC_LOAD       = 2'd1;
  localparam logic [1:0] OPC_STORE      = 2'd2;
  localparam logic [1:0] OPC_STORE_KEEP = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INIT  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  // STORE and STORE_KEEP share one state; the keep flavour is tracked apart.
  function automatic state_t decode_opcode(input logic [1:0] opcode);
    state_t st;
    case (opcode)
      OPC_INIT: st = ST_INIT;
      OPC_LOAD: st = ST_LOAD;
      default:  st = ST_STORE;
    endcase
    return st;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dca_matrix_move_row_counter.sv
`default_nettype none
// ============================================================================
// Module   : dca_matrix_move_row_counter
// Purpose  : Row beat counter for one LOAD/STORE command, with a flag that
//            marks the final beat (count == MATRIX_NUM_ROW-1).
// Ports    : clk, rstnn (sync, active-low), clear, incr -> last
// Revision : 1.0 - initial release
// ============================================================================
module dca_matrix_move_row_counter #(
  parameter int MATRIX_NUM_ROW = 8,
  parameter int BW_ROW_CNT     = 3
) (
  input  logic clk,
  input  logic rstnn,
  input  logic clear,
  input  logic incr,
  output logic last
);

  logic [BW_ROW_CNT-1:0] row_cnt;

  assign last = (row_cnt == BW_ROW_CNT'(MATRIX_NUM_ROW - 1));

  // The final beat does not advance the count, so it never wraps inside a
  // command; the next acceptance clears it anyway.
  always_ff @(posedge clk) begin
    if (!rstnn) begin
      row_cnt <= '0;
    end else if (clear) begin
      row_cnt <= '0;
    end else if (incr && !last) begin
      row_cnt <= row_cnt + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/dca_matrix_move_controller.sv
`default_nettype none
// ============================================================================
// Module   : dca_matrix_move_controller
// Purpose  : Turns INIT / LOAD / STORE / STORE_KEEP commands into row-wise
//            move traffic for one DCA matrix register.
// Ports    : cmd_valid/cmd_ready/cmd_opcode   - command handshake
//            wdata_valid/wdata_ready/wdata_list - LOAD row stream in
//            rdata_valid/rdata_ready/rdata_list - STORE row stream out
//            busy, done                          - status
//            init, move_wenable, move_wdata_list,
//            move_renable, move_rdata_list       - matrix register move port
// Revision : 1.0 - initial release
// ============================================================================
module dca_matrix_move_controller
  import dca_matrix_move_controller_pkg::*;
#(
  parameter int MATRIX_NUM_ROW = 8,
  parameter int BW_MOVE_DATA   = 256,
  parameter int BW_ROW_CNT     = (MATRIX_NUM_ROW > 1) ? $clog2(MATRIX_NUM_ROW) : 1
) (
  input  logic                    clk,
  input  logic                    rstnn,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_opcode,
  input  logic                    wdata_valid,
  output logic                    wdata_ready,
  input  logic [BW_MOVE_DATA-1:0] wdata_list,
  output logic                    rdata_valid,
  input  logic                    rdata_ready,
  output logic [BW_MOVE_DATA-1:0] rdata_list,
  output logic                    busy,
  output logic                    done,
  output logic                    init,
  output logic                    move_wenable,
  output logic [BW_MOVE_DATA-1:0] move_wdata_list,
  output logic                    move_renable,
  input  logic [BW_MOVE_DATA-1:0] move_rdata_list
);

  state_t state;
  logic   keep;
  logic   last;
  logic   accept;
  logic   load_beat;
  logic   store_beat;

  assign accept     = (state == ST_IDLE) && cmd_valid;
  assign load_beat  = (state == ST_LOAD) && wdata_valid;
  assign store_beat = (state == ST_STORE) && rdata_ready;

  dca_matrix_move_row_counter #(
    .MATRIX_NUM_ROW (MATRIX_NUM_ROW),
    .BW_ROW_CNT     (BW_ROW_CNT)
  ) u_row_counter (
    .clk   (clk),
    .rstnn (rstnn),
    .clear (accept),
    .incr  (load_beat || store_beat),
    .last  (last)
  );

  always_ff @(posedge clk) begin
    if (!rstnn) begin
      state <= ST_IDLE;
      keep  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state <= decode_opcode(cmd_opcode);
            keep  <= (cmd_opcode == OPC_STORE_KEEP);
          end
        end
        ST_INIT: begin
          state <= ST_IDLE;
          done  <= 1'b1;
        end
        ST_LOAD, ST_STORE: begin
          if ((load_beat || store_beat) && last) begin
            state <= ST_IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Status and handshakes depend only on registered state, so cmd_* never
  // reaches the move port combinationally.
  assign cmd_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign init        = (state == ST_INIT);
  assign wdata_ready = (state == ST_LOAD);
  assign rdata_valid = (state == ST_STORE);
  assign rdata_list  = move_rdata_list;

  // STORE_KEEP writes the row it reads back into the bottom, rotating the
  // matrix so that a full pass restores the original contents.
  assign move_renable = store_beat;
  assign move_wenable = load_beat || (store_beat && keep);

  always_comb begin
    move_wdata_list = '0;
    if (state == ST_LOAD) begin
      move_wdata_list = wdata_list;
    end else if ((state == ST_STORE) && keep) begin
      move_wdata_list = move_rdata_list;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dca_matrix_move_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_dca_matrix_move_controller
// Purpose  : Self-checking bench: behavioural matrix register, command-level
//            reference model, per-cycle compare and directed/random stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dca_matrix_move_controller;

  localparam int NR = 8;
  localparam int BW = 256;

  logic          clk = 1'b0;
  logic          rstnn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_opcode = 2'd0;
  logic          wdata_valid = 1'b0;
  logic          wdata_ready;
  logic [BW-1:0] wdata_list = '0;
  logic          rdata_valid;
  logic          rdata_ready = 1'b0;
  logic [BW-1:0] rdata_list;
  logic          busy;
  logic          done;
  logic          init;
  logic          move_wenable;
  logic [BW-1:0] move_wdata_list;
  logic          move_renable;
  logic [BW-1:0] move_rdata_list;

  always #5 clk = ~clk;

  dca_matrix_move_controller #(
    .MATRIX_NUM_ROW (NR),
    .BW_MOVE_DATA   (BW)
  ) dut (
    .clk             (clk),
    .rstnn           (rstnn),
    .cmd_valid       (cmd_valid),
    .cmd_ready       (cmd_ready),
    .cmd_opcode      (cmd_opcode),
    .wdata_valid     (wdata_valid),
    .wdata_ready     (wdata_ready),
    .wdata_list      (wdata_list),
    .rdata_valid     (rdata_valid),
    .rdata_ready     (rdata_ready),
    .rdata_list      (rdata_list),
    .busy            (busy),
    .done            (done),
    .init            (init),
    .move_wenable    (move_wenable),
    .move_wdata_list (move_wdata_list),
    .move_renable    (move_renable),
    .move_rdata_list (move_rdata_list)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- matrix register (environment) ----------------
  logic [BW-1:0] mat [NR];
  assign move_rdata_list = mat[0];

  always @(posedge clk) begin
    if (init) begin
      for (int i = 0; i < NR; i++) mat[i] <= '0;
    end else if (move_wenable || move_renable) begin
      for (int i = 0; i < NR - 1; i++) mat[i] <= mat[i+1];
      mat[NR-1] <= move_wenable ? move_wdata_list : '0;
    end
  end

  // ---------------- reference model ----------------
  // m_cmd: 0 idle, 1 init, 2 load, 3 store, 4 store_keep
  int            m_cmd = 0;
  int            m_beats = 0;
  bit            m_done = 0;
  bit            started = 0;
  bit            gold_ok = 1;
  logic [BW-1:0] gold [NR];
  logic [BW-1:0] load_rows [NR];

  initial begin
    for (int i = 0; i < NR; i++) begin
      mat[i]       = '0;
      gold[i]      = '0;
      load_rows[i] = '0;
    end
  end

  always @(posedge clk) begin
    if (!rstnn) begin
      started <= 1;
      if (m_cmd != 0) gold_ok <= 0;
      m_cmd   <= 0;
      m_beats <= 0;
      m_done  <= 0;
    end else begin
      m_done <= 0;
      case (m_cmd)
        0: if (cmd_valid) begin
          m_cmd   <= int'(cmd_opcode) + 1;
          m_beats <= 0;
        end
        1: begin
          m_cmd  <= 0;
          m_done <= 1;
          for (int i = 0; i < NR; i++) gold[i] <= '0;
          gold_ok <= 1;
        end
        2: if (wdata_valid) begin
          load_rows[m_beats] <= wdata_list;
          m_beats <= m_beats + 1;
          if (m_beats == NR - 1) begin
            m_cmd  <= 0;
            m_done <= 1;
            for (int i = 0; i < NR - 1; i++) gold[i] <= load_rows[i];
            gold[NR-1] <= wdata_list;
            gold_ok <= 1;
          end
        end
        3, 4: if (rdata_ready) begin
          m_beats <= m_beats + 1;
          if (m_beats == NR - 1) begin
            m_cmd  <= 0;
            m_done <= 1;
            if (m_cmd == 3) begin
              for (int i = 0; i < NR; i++) gold[i] <= '0;
              gold_ok <= 1;
            end
          end
        end
        default: m_cmd <= 0;
      endcase
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (started) begin
      logic          e_store;
      logic [BW-1:0] e_wdata;
      e_store = (m_cmd == 3) || (m_cmd == 4);
      e_wdata = (m_cmd == 2) ? wdata_list : (m_cmd == 4) ? move_rdata_list : '0;
      chk("busy",         busy,         m_cmd != 0);
      chk("cmd_ready",    cmd_ready,    m_cmd == 0);
      chk("done",         done,         m_done);
      chk("init",         init,         m_cmd == 1);
      chk("wdata_ready",  wdata_ready,  m_cmd == 2);
      chk("rdata_valid",  rdata_valid,  e_store);
      chk("move_renable", move_renable, e_store && rdata_ready);
      chk("move_wenable", move_wenable, ((m_cmd == 2) && wdata_valid) || ((m_cmd == 4) && rdata_ready));
      chk("move_wdata",   move_wdata_list, e_wdata);
      chk("rdata_list",   rdata_list,   move_rdata_list);
      if (e_store && rdata_ready && gold_ok)
        chk("store_row", rdata_list, gold[m_beats]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [1:0] op);
    int n = 0;
    cmd_valid  = 1'b1;
    cmd_opcode = op;
    while (!cmd_ready && n < 100) begin
      step();
      n++;
    end
    if (!cmd_ready) chk("cmd_accept_timeout", 0, 1);
    step();
    cmd_valid  = 1'b0;
    cmd_opcode = 2'($urandom);
  endtask

  task automatic run_load(input logic [BW-1:0] rows [NR], input int stall_pct,
                          output int wen_cnt, output int cycles);
    int k = 0;
    wen_cnt = 0;
    cycles  = 0;
    while (k < NR && cycles < 1000) begin
      wdata_valid = ($urandom_range(99) >= stall_pct);
      wdata_list  = wdata_valid ? rows[k] : {8{$urandom}};
      #1;
      if (move_wenable) wen_cnt++;
      if (wdata_valid && wdata_ready) k++;
      step();
      cycles++;
    end
    wdata_valid = 1'b0;
    if (k < NR) chk("load_beat_timeout", k, NR);
  endtask

  // mode 0: random stalls with stall_pct; mode 1: ready pattern 1,0,0 repeating
  task automatic run_store(input int mode, input int stall_pct, input bit hold_load,
                           output logic [BW-1:0] got [NR], output int ren_cnt, output int wen_cnt);
    int k = 0;
    int c = 0;
    ren_cnt = 0;
    wen_cnt = 0;
    for (int i = 0; i < NR; i++) got[i] = '0;
    if (hold_load) begin
      cmd_valid  = 1'b1;
      cmd_opcode = 2'd1;
    end
    while (k < NR && c < 1000) begin
      rdata_ready = (mode == 1) ? ((c % 3) == 0) : ($urandom_range(99) >= stall_pct);
      #1;
      if (hold_load) chk("lockout_cmd_ready", cmd_ready, 0);
      if (move_renable) ren_cnt++;
      if (move_wenable) wen_cnt++;
      if (rdata_valid && rdata_ready) begin
        got[k] = rdata_list;
        k++;
      end
      step();
      c++;
    end
    rdata_ready = 1'b0;
    if (k < NR) chk("store_beat_timeout", k, NR);
  endtask

  // ---------------- test sequence ----------------
  logic [BW-1:0] rows_a [NR];
  logic [BW-1:0] rows_b [NR];
  logic [BW-1:0] rows_c [NR];
  logic [BW-1:0] got1 [NR];
  logic [BW-1:0] got2 [NR];

  initial begin
    int wen, ren, cyc;

    rstnn = 1'b0;
    repeat (3) step();
    rstnn = 1'b1;
    chk("reset_cmd_ready", cmd_ready, 1);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);

    // INIT: pulse in T+1, done/cmd_ready in T+2
    send_cmd(2'd0);
    chk("init_t1_init", init, 1);
    chk("init_t1_busy", busy, 1);
    step();
    chk("init_t2_done", done, 1);
    chk("init_t2_init", init, 0);
    chk("init_t2_busy", busy, 0);
    step();
    chk("init_t3_done", done, 0);

    // LOAD rows 0..7 without stalls, then STORE them back
    for (int i = 0; i < NR; i++) rows_a[i] = BW'(i);
    send_cmd(2'd1);
    run_load(rows_a, 0, wen, cyc);
    chk("load_wen_count", wen, 8);
    chk("load_cycles", cyc, 8);
    chk("load_done", done, 1);
    send_cmd(2'd2);
    run_store(0, 0, 0, got1, ren, wen);
    for (int i = 0; i < NR; i++) chk("store_row_literal", got1[i], BW'(i));
    chk("store_ren_count", ren, 8);
    chk("store_wen_count", wen, 0);
    chk("store_done", done, 1);

    // STORE_KEEP twice back to back
    for (int i = 0; i < NR; i++) rows_b[i] = {8{$urandom}};
    send_cmd(2'd1);
    run_load(rows_b, 0, wen, cyc);
    send_cmd(2'd3);
    run_store(0, 0, 0, got1, ren, wen);
    chk("keep1_ren", ren, 8);
    chk("keep1_wen", wen, 8);
    send_cmd(2'd3);
    run_store(0, 0, 0, got2, ren, wen);
    chk("keep2_ren", ren, 8);
    chk("keep2_wen", wen, 8);
    for (int i = 0; i < NR; i++) begin
      chk("keep1_row", got1[i], rows_b[i]);
      chk("keep2_row", got2[i], rows_b[i]);
    end

    // Backpressure STORE with ready pattern 1,0,0,...
    send_cmd(2'd2);
    run_store(1, 0, 0, got1, ren, wen);
    chk("bp_ren", ren, 8);
    for (int i = 0; i < NR; i++) chk("bp_row", got1[i], rows_b[i]);

    // Busy lockout: LOAD held during a STORE, accepted in the done cycle
    send_cmd(2'd1);
    run_load(rows_b, 0, wen, cyc);
    send_cmd(2'd2);
    run_store(0, 20, 1, got1, ren, wen);
    chk("lockout_done", done, 1);
    chk("lockout_accept_ready", cmd_ready, 1);
    step();
    cmd_valid = 1'b0;
    chk("lockout_load_active", wdata_ready, 1);
    for (int i = 0; i < NR; i++) rows_c[i] = {8{$urandom}};
    run_load(rows_c, 25, wen, cyc);
    chk("lockout_load_wen", wen, 8);

    // Reset at LOAD beat 3
    send_cmd(2'd1);
    for (int i = 0; i < 3; i++) begin
      wdata_valid = 1'b1;
      wdata_list  = {8{$urandom}};
      step();
    end
    rstnn = 1'b0;
    step();
    rstnn = 1'b1;
    chk("rst_mid_cmd_ready", cmd_ready, 1);
    chk("rst_mid_wen", move_wenable, 0);
    chk("rst_mid_done", done, 0);
    wdata_valid = 1'b0;
    step();
    chk("rst_mid_done_next", done, 0);
    send_cmd(2'd0);
    step();

    // Randomised commands with random stalls
    for (int t = 0; t < 60; t++) begin
      logic [1:0] op;
      op = 2'($urandom_range(3));
      send_cmd(op);
      case (op)
        2'd0: step();
        2'd1: begin
          for (int i = 0; i < NR; i++) rows_c[i] = {8{$urandom}};
          run_load(rows_c, 30, wen, cyc);
        end
        default: run_store(0, 30, 0, got1, ren, wen);
      endcase
      repeat ($urandom_range(2)) step();
    end

    step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
